// File: rtl/shift_pkg.sv
// Shared constants and FSM state type for the sequential left shifter.
package shift_pkg;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : shift_pkg

// File: rtl/bit_shift_left_layer.sv
// One barrel-shifter stage: conditionally shift left by AMOUNT, filling vacated LSBs.
module bit_shift_left_layer #(
  parameter int WIDTH  = 32,
  parameter int AMOUNT = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic             enable,
  input  logic             fill_value,
  output logic [WIDTH-1:0] out
);

  assign out = enable ? {in[WIDTH-1-AMOUNT:0], {AMOUNT{fill_value}}} : in;

endmodule : bit_shift_left_layer

// File: rtl/bit_shift_left_seq.sv
// Sequential left shifter: one power-of-two stage per cycle, fixed latency for any amount.
module bit_shift_left_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int AMT_W = shift_pkg::AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amount,
  input  logic             fill_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int                 STAGE_W    = (AMT_W > 1) ? $clog2(AMT_W) : 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(AMT_W - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [STAGE_W-1:0] r_stage;
  logic [WIDTH-1:0]   r_data;
  logic [AMT_W-1:0]   r_amount;
  logic               r_fill;
  logic [WIDTH-1:0]   r_out;

  logic [WIDTH-1:0]   w_layer_out [AMT_W];
  logic [WIDTH-1:0]   w_stage_out;

  // Every stage sees the working register; the stage counter picks which result to keep.
  for (genvar k = 0; k < AMT_W; k++) begin : g_layer
    bit_shift_left_layer #(
      .WIDTH (WIDTH),
      .AMOUNT(2 ** k)
    ) u_layer (
      .in        (r_data),
      .enable    (r_amount[k]),
      .fill_value(r_fill),
      .out       (w_layer_out[k])
    );
  end

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_stage_out = r_data;
    for (int k = 0; k < AMT_W; k++) begin
      if (r_stage == STAGE_W'(k)) w_stage_out = w_layer_out[k];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (r_stage == LAST_STAGE) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so an aborted operation leaves no stale operand or result visible.
      r_state  <= IDLE;
      r_stage  <= '0;
      r_data   <= '0;
      r_amount <= '0;
      r_fill   <= 1'b0;
      r_out    <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_data   <= in;
            r_amount <= amount;
            r_fill   <= fill_value;
            r_stage  <= '0;
          end
        end
        SHIFT: begin
          r_data  <= w_stage_out;
          r_stage <= r_stage + STAGE_W'(1);
          if (r_stage == LAST_STAGE) r_out <= w_stage_out;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign out  = r_out;

endmodule : bit_shift_left_seq

// File: tb/tb_bit_shift_left_seq.sv
// Directed and random checks of bit_shift_left_seq against a shift-and-fill reference model.
module tb_bit_shift_left_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] din;
  logic [4:0]  amount;
  logic        fill;
  logic        busy;
  logic        done;
  logic [31:0] dout;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_out = '0;

  bit_shift_left_seq #(
    .WIDTH(32),
    .AMT_W(5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in        (din),
    .amount    (amount),
    .fill_value(fill),
    .busy      (busy),
    .done      (done),
    .out       (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [31:0] d, logic [4:0] a, logic f);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return (d << a) | (f ? ~(ones << a) : 32'h0);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the request is sampled at the next rising edge.
  task automatic issue(logic [31:0] d, logic [4:0] a, logic f);
    start  = 1'b1;
    din    = d;
    amount = a;
    fill   = f;
    exp_q.push_back(model(d, a, f));
  endtask

  // Counts negedges after issue until done; optionally keeps hammering start with a junk request.
  task automatic wait_done(input bit hold, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (hold) begin
          din    = 32'hFFFF_FFFF;
          amount = 5'd8;
          fill   = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      if (n == 3) check("out_hold_mid_op", dout, last_out);
    end while (!done && n < 20);
  endtask

  task automatic finish_op(string tag, int n);
    logic [31:0] exp;
    check({tag, "_latency"}, 32'(n), 32'd6);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check(tag, dout, exp);
    last_out = exp;
  endtask

  task automatic run_op(string tag, logic [31:0] d, logic [4:0] a, logic f);
    int n;
    issue(d, a, f);
    wait_done(1'b0, n);
    finish_op(tag, n);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  saw_done;

    rst_n  = 1'b0;
    start  = 1'b0;
    din    = '0;
    amount = '0;
    fill   = 1'b0;

    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_out", dout, 32'd0);
    rst_n = 1'b1;

    run_op("msb_walk", 32'h0000_0001, 5'd31, 1'b0);
    check("msb_walk_const", dout, 32'h8000_0000);
    run_op("nibble", 32'h1234_5678, 5'd4, 1'b0);
    check("nibble_const", dout, 32'h2345_6780);
    run_op("half_fill", 32'hFFFF_0000, 5'd16, 1'b1);
    check("half_fill_const", dout, 32'h0000_FFFF);
    run_op("amt_zero", 32'hA5A5_A5A5, 5'd0, 1'b1);
    check("amt_zero_const", dout, 32'hA5A5_A5A5);

    repeat (2) @(negedge clk);
    check("out_hold_idle", dout, 32'hA5A5_A5A5);

    // Requests while busy, including the DONE cycle, must be ignored.
    issue(32'h0000_0001, 5'd1, 1'b0);
    wait_done(1'b1, n);
    finish_op("busy_ignore", n);
    check("busy_ignore_const", dout, 32'h0000_0002);
    @(negedge clk);
    check("busy_ignore_idle", {31'b0, busy}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("busy_ignore_stay_idle", {31'b0, busy}, 32'd0);
    check("busy_ignore_out", dout, 32'h0000_0002);

    // Abort during the third SHIFT cycle.
    issue(32'h0F0F_0F0F, 5'd7, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_abort_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_out", dout, 32'd0);
    void'(exp_q.pop_front());
    last_out = '0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'b0, saw_done}, 32'd0);
    rst_n = 1'b1;
    run_op("post_reset", 32'h0000_0003, 5'd2, 1'b0);
    check("post_reset_const", dout, 32'h0000_000C);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("rand%0d", i), 32'($urandom), 5'($urandom_range(0, 31)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bit_shift_left_seq
